sb_ram2p_clr: RTL and testbench



---
 rtl/sb_ram2p_clr.sv | 151 +++++++++++++++
 tb/tb_sb_ram2p_clr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sb_ram2p_clr.sv
// ----------------------------------------------------------------------------
// sb_ram2p_clr
//
// Simple-dual-port synchronous RAM with a built-in sequential clear engine.
// One write port and one registered read port operate in the same cycle.
// The array is never reset directly. Instead, a hardware sweep writes INIT
// to every word, one word per clock edge. The sweep runs after reset
// release and again whenever clr is sampled high while idle.
//
// Parameters
//   DW    data width in bits
//   AW    address width in bits; DEPTH = 2**AW words
//   INIT  value written to every word by the clear sweep
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous active-high reset
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_data   in   write data
//   rd_en     in   read request
//   rd_addr   in   read address
//   rd_data   out  registered read data (holds when no read is accepted)
//   rd_valid  out  one-cycle strobe: rd_data was updated by an accepted read
//   clr       in   start a clear sweep (sampled on the clock edge)
//   busy      out  clear sweep in progress; wr/rd/clr are ignored while high
// ----------------------------------------------------------------------------
module sb_ram2p_clr #(
    parameter int              DW   = 8,
    parameter int              AW   = 4,
    parameter logic [DW-1:0]   INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          clr,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // ------------------------------------------------------------------
    // Next-state, memory write port and read port logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q;
        mem_wdata  = INIT;

        unique case (state_q)
            ST_CLEAR: begin
                // Sweep one word per edge; user ports are ignored here.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (clr) begin
                    // clr wins over a same-edge write and read: both are
                    // dropped, and nothing is written on this edge.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (wr_en) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr;
                        mem_wdata = wr_data;
                    end
                    if (rd_en) begin
                        rd_valid_d = 1'b1;
                        // Write-first on an address collision: the array
                        // update lands on the same edge, so bypass it.
                        if (wr_en && (wr_addr == rd_addr)) begin
                            rd_data_d = wr_data;
                        end else begin
                            rd_data_d = mem[rd_addr];
                        end
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and read-port registers (asynchronously reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: no reset, initialised by the sweep only
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // busy decodes a register directly, so it has no path from the inputs.
    assign busy     = (state_q == ST_CLEAR);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sb_ram2p_clr.sv
// ----------------------------------------------------------------------------
// tb_sb_ram2p_clr
//
// Directed testbench for sb_ram2p_clr with DW=8, AW=3, INIT=8'hA5.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, which is well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_sb_ram2p_clr;

    localparam int            DW    = 8;
    localparam int            AW    = 3;
    localparam int            DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT  = 8'hA5;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          clr;
    logic          busy;

    int n_tests;
    int n_fail;

    sb_ram2p_clr #(
        .DW   (DW),
        .AW   (AW),
        .INIT (INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr      (clr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        clr     = 1'b0;

        // Reset state, applied before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",     32'(busy),     32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        step();
        rst = 1'b0;

        // Sweep after release: busy high for exactly DEPTH edges.
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            chk($sformatf("init_busy_e%0d", i), 32'(busy), (i < DEPTH) ? 32'd1 : 32'd0);
        end

        // Back-to-back reads of every address, rd_en held high.
        for (int i = 0; i < DEPTH; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            step();
            chk($sformatf("init_rv_%0d", i), 32'(rd_valid), 32'd1);
            chk($sformatf("init_rd_%0d", i), 32'(rd_data),  32'hA5);
        end
        rd_en = 1'b0;
        step();
        chk("idle_rv_drop", 32'(rd_valid), 32'd0);
        chk("idle_rd_hold", 32'(rd_data),  32'hA5);

        // Write 3C to addr 5, then read it on the next edge.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        step();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd5;
        step();
        chk("wr5_rd", 32'(rd_data),  32'h3C);
        chk("wr5_rv", 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
        step();
        chk("wr5_rv_drop", 32'(rd_valid), 32'd0);
        chk("wr5_rd_hold", 32'(rd_data),  32'h3C);

        // Collision at addr 2: write-first returns the new data.
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77;
        rd_en = 1'b1; rd_addr = 3'd2;
        step();
        chk("coll_rd", 32'(rd_data),  32'h77);
        chk("coll_rv", 32'(rd_valid), 32'd1);
        // Write addr 2 while reading addr 3: the read sees old mem[3].
        wr_data = 8'h66; rd_addr = 3'd3;
        step();
        chk("nocoll_rd3", 32'(rd_data), 32'hA5);
        wr_en = 1'b0; rd_addr = 3'd2;
        step();
        chk("rd2_after", 32'(rd_data), 32'h66);

        // clr together with a write and a read: both are dropped.
        clr = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
        rd_en = 1'b1; rd_addr = 3'd1;
        step();
        clr = 1'b0;
        chk("clr_busy", 32'(busy),     32'd1);
        chk("clr_rv",   32'(rd_valid), 32'd0);
        // During the sweep, keep requesting a write and a read.
        wr_addr = 3'd4; wr_data = 8'h99;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk($sformatf("clr_busy_e%0d", k), 32'(busy),     (k < DEPTH) ? 32'd1 : 32'd0);
            chk($sformatf("clr_rv_e%0d", k),   32'(rd_valid), 32'd0);
        end
        wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            step();
            chk($sformatf("clr_rd_%0d", i), 32'(rd_data), 32'hA5);
        end
        rd_en = 1'b0;
        step();

        // Asynchronous reset mid-sweep at cnt=4.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy),     32'd1);
        chk("arst_rv",   32'(rd_valid), 32'd0);
        chk("arst_rd",   32'(rd_data),  32'd0);
        step();
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            chk($sformatf("rsweep_busy_e%0d", i), 32'(busy), (i < DEPTH) ? 32'd1 : 32'd0);
        end
        rd_en = 1'b1; rd_addr = 3'd7;
        step();
        chk("rsweep_rd7", 32'(rd_data),  32'hA5);
        chk("rsweep_rv",  32'(rd_valid), 32'd1);
        rd_en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
